load_store_unit: RTL

- Memory stage directly downstream of the execute ALU.
- Consumes the ALU sum (rs1 + imm) as the effective address, rs2 as store data, and funct3 as the access size/sign.
- Performs one RV32I load or store over a single-outstanding req/ready memory port.
- Returns a sign- or zero-extended load result, or a misalignment/illegal error, with a one-cycle done pulse to writeback.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, FSM states
// and the legality rule for a load/store request.
package lsu_pkg;

    localparam int REGISTER_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    // An access is illegal unless it is exactly one of load/store with a size code that kind supports
    function automatic logic access_illegal(input logic is_load, input logic is_store,
                                            input logic [2:0] funct3);
        if (is_load == is_store) begin
            return 1'b1;
        end
        if (is_load) begin
            return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        return !(funct3 inside {F3_B, F3_H, F3_W});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data replication and byte mask,
// alignment check, and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  store_size,
    input  logic [1:0]  store_offset,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic        misaligned,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Size code 11 never reaches memory (illegal), so it shares the word row
    always_comb begin
        wdata      = store_data;
        wmask      = 4'b1111;
        misaligned = 1'b0;
        case (store_size)
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wmask = 4'b0001 << store_offset;
            end
            2'b01: begin
                wdata      = {2{store_data[15:0]}};
                wmask      = store_offset[1] ? 4'b1100 : 4'b0011;
                misaligned = store_offset[0];
            end
            default: begin
                misaligned = (store_offset != 2'b00);
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (load_offset)
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            2'b11:   byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = load_offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (load_funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: issues one load or store over a req/ready port and
// returns the extended load result or an error with a one-cycle done pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int register_width = REGISTER_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_load,
    input  logic                      is_store,
    input  logic [2:0]                funct3,
    input  logic [register_width-1:0] addr,
    input  logic [register_width-1:0] store_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [register_width-1:0] mem_addr,
    output logic [register_width-1:0] mem_wdata,
    output logic [3:0]                mem_wmask,
    input  logic                      mem_ready,
    input  logic [register_width-1:0] mem_rdata,
    output logic [register_width-1:0] load_data,
    output logic                      done,
    output logic                      err,
    output logic                      busy
);

    state_t state, state_next;

    logic [2:0]                funct3_q, funct3_next;
    logic [1:0]                offset_q, offset_next;
    logic                      load_kind_q, load_kind_next;
    logic                      mem_req_next, mem_we_next, done_next, err_next, busy_next;
    logic [register_width-1:0] mem_addr_next, mem_wdata_next, load_data_next;
    logic [3:0]                mem_wmask_next;

    logic [register_width-1:0] aligned_wdata, aligned_load;
    logic [3:0]                aligned_wmask;
    logic                      misaligned;

    lsu_align u_align (
        .store_size   (funct3[1:0]),
        .store_offset (addr[1:0]),
        .store_data   (store_data),
        .wdata        (aligned_wdata),
        .wmask        (aligned_wmask),
        .misaligned   (misaligned),
        .load_funct3  (funct3_q),
        .load_offset  (offset_q),
        .rdata        (mem_rdata),
        .load_data    (aligned_load)
    );

    // Error path spends two cycles in RESP so its done lands at the same
    // distance from start as a zero-wait memory access would.
    always_comb begin
        state_next     = state;
        funct3_next    = funct3_q;
        offset_next    = offset_q;
        load_kind_next = load_kind_q;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_wmask_next = mem_wmask;
        load_data_next = load_data;
        done_next      = 1'b0;
        err_next       = err;
        busy_next      = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_next      = 1'b1;
                    funct3_next    = funct3;
                    offset_next    = addr[1:0];
                    load_kind_next = is_load;
                    if (access_illegal(is_load, is_store, funct3) || misaligned) begin
                        state_next     = RESP;
                        err_next       = 1'b1;
                        mem_req_next   = 1'b0;
                        mem_we_next    = 1'b0;
                        mem_wmask_next = MASK_NONE;
                    end else begin
                        state_next     = REQ;
                        err_next       = 1'b0;
                        mem_req_next   = 1'b1;
                        mem_we_next    = is_store;
                        mem_addr_next  = {addr[register_width-1:2], 2'b00};
                        mem_wdata_next = is_store ? aligned_wdata : '0;
                        mem_wmask_next = is_store ? aligned_wmask : MASK_NONE;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_next     = RESP;
                    mem_req_next   = 1'b0;
                    mem_wmask_next = MASK_NONE;
                    done_next      = 1'b1;
                    if (load_kind_q) begin
                        load_data_next = aligned_load;
                    end
                end
            end
            RESP: begin
                if (done) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end else begin
                    done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            funct3_q    <= '0;
            offset_q    <= '0;
            load_kind_q <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= MASK_NONE;
            load_data   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            funct3_q    <= funct3_next;
            offset_q    <= offset_next;
            load_kind_q <= load_kind_next;
            mem_req     <= mem_req_next;
            mem_we      <= mem_we_next;
            mem_addr    <= mem_addr_next;
            mem_wdata   <= mem_wdata_next;
            mem_wmask   <= mem_wmask_next;
            load_data   <= load_data_next;
            done        <= done_next;
            err         <= err_next;
            busy        <= busy_next;
        end
    end

endmodule
